ac97_rx_deframer: RTL
=====================

AC97_RX_DEFRAMER -- requirements
Module: ac97_rx_deframer

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 256, meaning AC-link frame length in bits.
REQ-002 SHALL have parameter SLOT_BITS, default 20, meaning bits per data slot (tag is 16).
REQ-003 SHALL have port AUDIO_BIT_CLK  input  1  codec bit clock; the block's only clock.
REQ-004 SHALL have port RESET_B  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port AUDIO_SYNC  input  1  frame sync as driven to the codec; high from last bit of previous frame through tag.
REQ-006 SHALL have port AUDIO_SDATA_IN  input  1  serial data from codec, MSB of tag first.
REQ-007 SHALL have port locked  output  1  frame alignment acquired.
REQ-008 SHALL have port tag  output  16  last complete tag slot; [15]=codec ready, [14:3]=slot1..12 valid.
REQ-009 SHALL have port status_addr  output  7  register index from slot 1 bits [18:12].
REQ-010 SHALL have port status_data  output  16  register value from slot 2 bits [19:4].
REQ-011 SHALL have port status_valid  output  1  one-cycle pulse, status_addr/status_data updated.
REQ-012 SHALL have port pcm_left  output  16  record PCM from slot 3 bits [19:4].
REQ-013 SHALL have port pcm_right  output  16  record PCM from slot 4 bits [19:4].
REQ-014 SHALL have port pcm_valid  output  1  one-cycle pulse, pcm_left/pcm_right updated.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse on sync misalignment.

Function
REQ-016 SHALL capture AUDIO_SDATA_IN and AUDIO_SYNC together on the falling edge of AUDIO_BIT_CLK; all other state SHALL update on the rising edge.
REQ-017 SHALL define a sync rise as captured sync=1 with the previous captured sync=0; the bit carrying the rise is bit 255, and the next captured bit is bit 0 (tag[15]).
REQ-018 SHALL implement states HUNT and LOCK; HUNT->LOCK on first sync rise, bit counter loaded so the next bit is 0; locked=1 in LOCK only.
REQ-019 In LOCK, the 8-bit bit counter SHALL wrap 255->0.
REQ-020 In LOCK, a sync rise at a counter value other than 255 SHALL pulse frame_err, realign so the next bit is 0, and remain in LOCK.
REQ-021 In LOCK, absence of a sync rise at bit 255 SHALL pulse frame_err and return to HUNT with locked=0.
REQ-022 Bits 0-15 SHALL shift into tag MSB first; tag output SHALL update on the rising edge following capture of bit 15.
REQ-023 Slot n (n>=1) SHALL occupy bits 16+20(n-1) .. 35+20(n-1); slot 1 ends at bit 35, slot 2 at 55, slot 3 at 75, slot 4 at 95; bits 96-255 are ignored.
REQ-024 At the end of slot 2, status_addr/status_data SHALL load and status_valid SHALL pulse for exactly one cycle, only if the current tag has bits 15, 14 and 13 all set.
REQ-025 At the end of slot 4, pcm_left/pcm_right SHALL load and pcm_valid SHALL pulse for exactly one cycle, only if the current tag has bit 15 and at least one of bits 12/11 set; a slot with a clear valid bit SHALL load 0.
REQ-026 Outputs SHALL hold their value between updates; no pulse SHALL occur in HUNT or in a frame aborted by realignment.
REQ-027 Latency SHALL be exactly one rising edge from capture of a slot's last bit to its output/pulse.

Reset
REQ-028 On RESET_B=0, state SHALL be HUNT, the counter 0, and locked, tag, status_addr, status_data, status_valid, pcm_left, pcm_right, pcm_valid and frame_err all 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, no pulse SHALL occur before a new sync rise.

Structure
REQ-030 A shared package SHALL hold the state encoding, FRAME_BITS/SLOT_BITS defaults, and slot end indices (15, 35, 55, 75, 95).
REQ-031 A single sub-module, ac97_slot_shifter, SHALL hold the 20-bit MSB-first shift register with its load/clear.

Verification
REQ-032 Sync rise, then a frame with tag 0xE000, slot1 addr 0x26, slot2 0x000F -> locked=1, status_valid pulse, status_addr=0x26, status_data=0x000F.
REQ-033 Tag 0x9800, slot3 0x1234, slot4 0xABCD -> pcm_valid pulse at bit-95+1 edge, pcm_left=0x1234, pcm_right=0xABCD.
REQ-034 Tag 0x7800 (codec not ready) -> no status_valid or pcm_valid pulse; tag=0x7800.
REQ-035 Sync rise at bit 100 -> frame_err pulse, locked stays 1, next frame decodes correctly.
REQ-036 Sync held low across bit 255 -> frame_err pulse, locked=0; RESET_B low at bit 40 -> all outputs 0, no pulses until the next sync rise.

Source files
------------

// File: rtl/ac97_rx_deframer_pkg.sv
// ac97_rx_deframer_pkg
// Shared constants for the AC-link receive deframer: FSM state encoding,
// default frame/slot geometry and the bit index at which each decoded slot ends.
package ac97_rx_deframer_pkg;

  localparam int unsigned FrameBitsDef = 256;
  localparam int unsigned SlotBitsDef  = 20;
  localparam int unsigned TagBits      = 16;

  // FSM encoding
  localparam logic [0:0] StHunt = 1'b0;
  localparam logic [0:0] StLock = 1'b1;

  // Index of the last bit of slot n (slot 0 is the tag).
  function automatic int unsigned slot_end(input int unsigned n, input int unsigned slot_bits);
    return TagBits - 1 + n * slot_bits;
  endfunction

  // Slot end indices for the default geometry.
  localparam int unsigned TagEnd   = slot_end(0, SlotBitsDef);  // 15
  localparam int unsigned Slot1End = slot_end(1, SlotBitsDef);  // 35
  localparam int unsigned Slot2End = slot_end(2, SlotBitsDef);  // 55
  localparam int unsigned Slot3End = slot_end(3, SlotBitsDef);  // 75
  localparam int unsigned Slot4End = slot_end(4, SlotBitsDef);  // 95

endpackage

// File: rtl/ac97_slot_shifter.sv
// ac97_slot_shifter
// MSB-first serial-in shift register holding the most recent Width bits of a slot.
// Ports:
//   clk_i      - clock (rising edge)
//   rst_ni     - asynchronous active-low reset
//   clr_i      - synchronous clear (takes priority over shift)
//   shift_en_i - shift bit_i into the LSB
//   bit_i      - serial input bit
//   data_o     - current register contents
module ac97_slot_shifter #(
  parameter int unsigned Width = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (clr_i) begin
      shift_d = '0;
    end else if (shift_en_i) begin
      shift_d = {shift_q[Width-2:0], bit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign data_o = shift_q;

endmodule

// File: rtl/ac97_rx_deframer.sv
// ac97_rx_deframer
// Receives the AC-link SDATA_IN stream, aligns to frame sync and decodes the tag,
// the status register slots (1, 2) and the record PCM slots (3, 4).
// Ports:
//   AUDIO_BIT_CLK  - codec bit clock (capture on falling edge, logic on rising edge)
//   RESET_B        - asynchronous active-low reset
//   AUDIO_SYNC     - frame sync as driven to the codec
//   AUDIO_SDATA_IN - serial data from codec, MSB first
//   locked         - frame alignment acquired
//   tag            - last complete tag slot
//   status_addr/status_data/status_valid - status register read-back, one-cycle pulse
//   pcm_left/pcm_right/pcm_valid         - record PCM samples, one-cycle pulse
//   frame_err      - one-cycle pulse on sync misalignment or missing sync
module ac97_rx_deframer
  import ac97_rx_deframer_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FrameBitsDef,
  parameter int unsigned SLOT_BITS  = SlotBitsDef
) (
  input  logic        AUDIO_BIT_CLK,
  input  logic        RESET_B,
  input  logic        AUDIO_SYNC,
  input  logic        AUDIO_SDATA_IN,
  output logic        locked,
  output logic [15:0] tag,
  output logic [6:0]  status_addr,
  output logic [15:0] status_data,
  output logic        status_valid,
  output logic [15:0] pcm_left,
  output logic [15:0] pcm_right,
  output logic        pcm_valid,
  output logic        frame_err
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);

  // Default geometry resolves to the package's fixed indices.
  localparam bit IsDef = (SLOT_BITS == SlotBitsDef);
  localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] EndTag  = CntW'(TagEnd);
  localparam logic [CntW-1:0] EndS1   = CntW'(IsDef ? Slot1End : slot_end(1, SLOT_BITS));
  localparam logic [CntW-1:0] EndS2   = CntW'(IsDef ? Slot2End : slot_end(2, SLOT_BITS));
  localparam logic [CntW-1:0] EndS3   = CntW'(IsDef ? Slot3End : slot_end(3, SLOT_BITS));
  localparam logic [CntW-1:0] EndS4   = CntW'(IsDef ? Slot4End : slot_end(4, SLOT_BITS));

  // Falling-edge capture of data and sync
  logic sync_f_q, sdata_f_q;

  always_ff @(negedge AUDIO_BIT_CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      sync_f_q  <= 1'b0;
      sdata_f_q <= 1'b0;
    end else begin
      sync_f_q  <= AUDIO_SYNC;
      sdata_f_q <= AUDIO_SDATA_IN;
    end
  end

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync_prev_q;
  logic [15:0]     tag_q, tag_d;
  logic [6:0]      slot1_addr_q, slot1_addr_d;
  logic [15:0]     slot3_q, slot3_d;
  logic [6:0]      status_addr_q, status_addr_d;
  logic [15:0]     status_data_q, status_data_d;
  logic            status_valid_q, status_valid_d;
  logic [15:0]     pcm_left_q, pcm_left_d;
  logic [15:0]     pcm_right_q, pcm_right_d;
  logic            pcm_valid_q, pcm_valid_d;
  logic            frame_err_q, frame_err_d;

  logic                 shift_clr, shift_en;
  logic [SLOT_BITS-1:0] shift_q;
  logic [SLOT_BITS-1:0] word;
  logic                 sync_rise;

  ac97_slot_shifter #(
    .Width (SLOT_BITS)
  ) u_shifter (
    .clk_i      (AUDIO_BIT_CLK),
    .rst_ni     (RESET_B),
    .clr_i      (shift_clr),
    .shift_en_i (shift_en),
    .bit_i      (sdata_f_q),
    .data_o     (shift_q)
  );

  // Slot word including the bit being processed this cycle.
  assign word      = {shift_q[SLOT_BITS-2:0], sdata_f_q};
  assign sync_rise = sync_f_q & ~sync_prev_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tag_d          = tag_q;
    slot1_addr_d   = slot1_addr_q;
    slot3_d        = slot3_q;
    status_addr_d  = status_addr_q;
    status_data_d  = status_data_q;
    pcm_left_d     = pcm_left_q;
    pcm_right_d    = pcm_right_q;
    status_valid_d = 1'b0;
    pcm_valid_d    = 1'b0;
    frame_err_d    = 1'b0;
    shift_clr      = 1'b0;
    shift_en       = 1'b0;

    if (state_q == StHunt) begin
      shift_clr = 1'b1;
      if (sync_rise) begin
        state_d = StLock;
        cnt_d   = '0;
      end
    end else begin
      if (sync_rise) begin
        // The rise bit is treated as bit 255 wherever it lands.
        cnt_d     = '0;
        shift_clr = 1'b1;
        if (cnt_q != LastBit) begin
          frame_err_d = 1'b1;
        end
      end else if (cnt_q == LastBit) begin
        frame_err_d = 1'b1;
        state_d     = StHunt;
        cnt_d       = '0;
        shift_clr   = 1'b1;
      end else begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == EndTag) begin
          tag_d = word[15:0];
        end
        if (cnt_q == EndS1) begin
          slot1_addr_d = word[SLOT_BITS-2 -: 7];
        end
        if (cnt_q == EndS2 && tag_q[15] && tag_q[14] && tag_q[13]) begin
          status_addr_d  = slot1_addr_q;
          status_data_d  = word[SLOT_BITS-1 -: 16];
          status_valid_d = 1'b1;
        end
        if (cnt_q == EndS3) begin
          slot3_d = word[SLOT_BITS-1 -: 16];
        end
        if (cnt_q == EndS4 && tag_q[15] && (tag_q[12] || tag_q[11])) begin
          pcm_left_d  = tag_q[12] ? slot3_q : 16'h0000;
          pcm_right_d = tag_q[11] ? word[SLOT_BITS-1 -: 16] : 16'h0000;
          pcm_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge AUDIO_BIT_CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q        <= StHunt;
      cnt_q          <= '0;
      sync_prev_q    <= 1'b0;
      tag_q          <= '0;
      slot1_addr_q   <= '0;
      slot3_q        <= '0;
      status_addr_q  <= '0;
      status_data_q  <= '0;
      status_valid_q <= 1'b0;
      pcm_left_q     <= '0;
      pcm_right_q    <= '0;
      pcm_valid_q    <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sync_prev_q    <= sync_f_q;
      tag_q          <= tag_d;
      slot1_addr_q   <= slot1_addr_d;
      slot3_q        <= slot3_d;
      status_addr_q  <= status_addr_d;
      status_data_q  <= status_data_d;
      status_valid_q <= status_valid_d;
      pcm_left_q     <= pcm_left_d;
      pcm_right_q    <= pcm_right_d;
      pcm_valid_q    <= pcm_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign locked       = (state_q == StLock);
  assign tag          = tag_q;
  assign status_addr  = status_addr_q;
  assign status_data  = status_data_q;
  assign status_valid = status_valid_q;
  assign pcm_left     = pcm_left_q;
  assign pcm_right    = pcm_right_q;
  assign pcm_valid    = pcm_valid_q;
  assign frame_err    = frame_err_q;

endmodule
